// File: rtl/sfp_link_sequencer.sv
// SFP+ bring-up and recovery sequencer: debounces module presence and LOS, runs the
// TX_FAULT recovery pulse loop, and holds the PHY in reset until the PLLs lock.
module sfp_link_sequencer #(
  parameter int p_DEBOUNCE_CYCLES         = 100000,
  parameter int p_TX_INIT_CYCLES          = 30000000,
  parameter int p_TX_DISABLE_PULSE_CYCLES = 1000,
  parameter int p_PHY_RESET_CYCLES        = 16,
  parameter int p_LOCK_TIMEOUT_CYCLES     = 100000000,
  parameter int p_MAX_FAULT_RETRIES       = 3
) (
  input  logic                                     i_clock,
  input  logic                                     i_reset,
  input  logic                                     i_enable,
  input  logic                                     i_sfp_mod0_prsnt_n,
  input  logic                                     i_sfp_los,
  input  logic                                     i_sfp_tx_fault,
  input  logic                                     i_xcvr_pll_locked,
  input  logic                                     i_xgmii_pll_locked,
  input  logic                                     i_xcvr_tx_ready,
  input  logic                                     i_xcvr_rx_ready,
  input  logic                                     i_rx_block_lock,
  output logic                                     o_sfp_tx_disable,
  output logic                                     o_phy_reset,
  output logic                                     o_link_up,
  output logic                                     o_fault_halt,
  output logic [3:0]                               o_state,
  output logic [$clog2(p_MAX_FAULT_RETRIES+1)-1:0] o_fault_count
);

  localparam int c_CNT_W   = $clog2(p_MAX_FAULT_RETRIES + 1);
  localparam int c_MAX_A   = (p_DEBOUNCE_CYCLES > p_TX_INIT_CYCLES) ? p_DEBOUNCE_CYCLES : p_TX_INIT_CYCLES;
  localparam int c_MAX_B   = (p_TX_DISABLE_PULSE_CYCLES > p_PHY_RESET_CYCLES) ?
                             p_TX_DISABLE_PULSE_CYCLES : p_PHY_RESET_CYCLES;
  localparam int c_MAX_C   = (c_MAX_A > c_MAX_B) ? c_MAX_A : c_MAX_B;
  localparam int c_TIMER_MAX = (c_MAX_C > p_LOCK_TIMEOUT_CYCLES) ? c_MAX_C : p_LOCK_TIMEOUT_CYCLES;
  localparam int c_TIMER_W = $clog2(c_TIMER_MAX + 1);

  localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(p_MAX_FAULT_RETRIES);

  typedef logic [c_TIMER_W-1:0] timer_t;

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_ABSENT      = 4'd1,
    S_TX_INIT     = 4'd2,
    S_WAIT_SIGNAL = 4'd3,
    S_PHY_RESET   = 4'd4,
    S_WAIT_LOCK   = 4'd5,
    S_LINK_UP     = 4'd6,
    S_FAULT_PULSE = 4'd7,
    S_FAULT_HALT  = 4'd8
  } state_t;

  state_t     state, next_state;
  timer_t     timer;
  logic       timer_done;
  logic       restart;
  logic [7:0] async_in, sync_meta, sync_q;
  logic       prsnt_n_s, los_s, tx_fault_s, xcvr_pll_s, xgmii_pll_s;
  logic       tx_ready_s, rx_ready_s, block_lock_s;
  state_t     fault_target;

  // Timer is loaded with (constant - 1) so a state with constant N lasts exactly N cycles.
  function automatic timer_t load_value(input state_t s);
    case (s)
      S_ABSENT, S_WAIT_SIGNAL: return timer_t'(p_DEBOUNCE_CYCLES - 1);
      S_TX_INIT:               return timer_t'(p_TX_INIT_CYCLES - 1);
      S_PHY_RESET:             return timer_t'(p_PHY_RESET_CYCLES - 1);
      S_WAIT_LOCK:             return timer_t'(p_LOCK_TIMEOUT_CYCLES - 1);
      S_FAULT_PULSE:           return timer_t'(p_TX_DISABLE_PULSE_CYCLES - 1);
      default:                 return '0;
    endcase
  endfunction

  assign async_in = {i_sfp_mod0_prsnt_n, i_sfp_los, i_sfp_tx_fault, i_xcvr_pll_locked,
                     i_xgmii_pll_locked, i_xcvr_tx_ready, i_xcvr_rx_ready, i_rx_block_lock};

  // NOTE: synchronizer flops carry no state worth resetting; they refill from the pins in two cycles.
  always_ff @(posedge i_clock) begin
    sync_meta <= async_in;
    sync_q    <= sync_meta;
  end

  assign {prsnt_n_s, los_s, tx_fault_s, xcvr_pll_s,
          xgmii_pll_s, tx_ready_s, rx_ready_s, block_lock_s} = sync_q;

  assign timer_done = (timer == '0);
  // The (max+1)-th fault detection halts instead of issuing another pulse.
  assign fault_target = (o_fault_count == c_MAX_CNT) ? S_FAULT_HALT : S_FAULT_PULSE;

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    restart    = 1'b0;
    if (!i_enable) begin
      next_state = S_IDLE;
    end else if (prsnt_n_s && state != S_IDLE && state != S_ABSENT) begin
      next_state = S_ABSENT;
    end else if (tx_fault_s && state inside {S_WAIT_SIGNAL, S_PHY_RESET, S_WAIT_LOCK, S_LINK_UP}) begin
      next_state = fault_target;
    end else begin
      case (state)
        S_IDLE: next_state = S_ABSENT;
        S_ABSENT: begin
          if (prsnt_n_s)       restart    = 1'b1;
          else if (timer_done) next_state = S_TX_INIT;
        end
        S_TX_INIT: begin
          if (timer_done) next_state = tx_fault_s ? fault_target : S_WAIT_SIGNAL;
        end
        S_WAIT_SIGNAL: begin
          if (los_s)           restart    = 1'b1;
          else if (timer_done) next_state = S_PHY_RESET;
        end
        S_PHY_RESET: begin
          if (timer_done && xcvr_pll_s && xgmii_pll_s) next_state = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (tx_ready_s && rx_ready_s && block_lock_s) next_state = S_LINK_UP;
          else if (timer_done)                          next_state = S_PHY_RESET;
          else if (los_s)                               next_state = S_WAIT_SIGNAL;
        end
        S_LINK_UP: begin
          if (los_s) next_state = S_WAIT_SIGNAL;
          else if (!block_lock_s || !rx_ready_s || !xcvr_pll_s || !xgmii_pll_s)
            next_state = S_PHY_RESET;
        end
        S_FAULT_PULSE: begin
          if (timer_done) next_state = S_TX_INIT;
        end
        S_FAULT_HALT: next_state = S_FAULT_HALT;
        default:      next_state = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state            <= S_IDLE;
      timer            <= '0;
      o_fault_count    <= '0;
      o_sfp_tx_disable <= 1'b1;
      o_phy_reset      <= 1'b1;
      o_link_up        <= 1'b0;
      o_fault_halt     <= 1'b0;
    end else begin
      state <= next_state;

      if (next_state != state)  timer <= load_value(next_state);
      else if (restart)         timer <= load_value(state);
      else if (!timer_done)     timer <= timer - timer_t'(1);

      if (next_state != state) begin
        if (next_state == S_FAULT_PULSE && o_fault_count != c_MAX_CNT)
          o_fault_count <= o_fault_count + c_CNT_W'(1);
        else if (next_state inside {S_IDLE, S_ABSENT, S_LINK_UP})
          o_fault_count <= '0;
      end

      // Outputs are decoded from next_state so they change on the same edge as the state.
      o_sfp_tx_disable <= next_state inside {S_IDLE, S_ABSENT, S_FAULT_PULSE, S_FAULT_HALT};
      o_phy_reset      <= !(next_state inside {S_WAIT_LOCK, S_LINK_UP});
      o_link_up        <= (next_state == S_LINK_UP);
      o_fault_halt     <= (next_state == S_FAULT_HALT);
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_sfp_link_sequencer.sv
// Self-checking bench for sfp_link_sequencer: directed bring-up/fault scenarios plus random
// stimulus, all compared every cycle against a cycle-count reference model of the sequencer.
module tb_sfp_link_sequencer;

  localparam int DEB  = 4;
  localparam int TXI  = 10;
  localparam int PUL  = 5;
  localparam int PHYC = 4;
  localparam int TMO  = 20;
  localparam int MAXR = 3;

  localparam int ST_IDLE = 0, ST_ABSENT = 1, ST_TX_INIT = 2, ST_WAIT_SIGNAL = 3, ST_PHY_RESET = 4;
  localparam int ST_WAIT_LOCK = 5, ST_LINK_UP = 6, ST_PULSE = 7, ST_HALT = 8;

  logic clk = 1'b0;
  logic rst, en, prsnt_n, los, fault, xpll, gpll, txr, rxr, blk;
  logic txd, phy, link, halt;
  logic [3:0] st;
  logic [1:0] cnt;

  sfp_link_sequencer #(
    .p_DEBOUNCE_CYCLES         (DEB),
    .p_TX_INIT_CYCLES          (TXI),
    .p_TX_DISABLE_PULSE_CYCLES (PUL),
    .p_PHY_RESET_CYCLES        (PHYC),
    .p_LOCK_TIMEOUT_CYCLES     (TMO),
    .p_MAX_FAULT_RETRIES       (MAXR)
  ) dut (
    .i_clock            (clk),
    .i_reset            (rst),
    .i_enable           (en),
    .i_sfp_mod0_prsnt_n (prsnt_n),
    .i_sfp_los          (los),
    .i_sfp_tx_fault     (fault),
    .i_xcvr_pll_locked  (xpll),
    .i_xgmii_pll_locked (gpll),
    .i_xcvr_tx_ready    (txr),
    .i_xcvr_rx_ready    (rxr),
    .i_rx_block_lock    (blk),
    .o_sfp_tx_disable   (txd),
    .o_phy_reset        (phy),
    .o_link_up          (link),
    .o_fault_halt       (halt),
    .o_state            (st),
    .o_fault_count      (cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Reference model: state plus "cycles spent in state" and "consecutive good samples".
  bit   exp_txd [9] = '{1, 1, 0, 0, 0, 0, 0, 1, 1};
  bit   exp_phy [9] = '{1, 1, 1, 1, 1, 0, 0, 1, 1};
  int   m_state = 0, m_time = 0, m_run = 0, m_count = 0, m_next, m_ft;
  logic [7:0] m_d0 = '0, m_d1 = '0, m_s;
  bit   sp, sl, sf, sx, sg, str, srr, sb;
  bit   started = 0;

  always @(posedge clk) begin
    m_s  = m_d1;
    m_d1 = m_d0;
    m_d0 = {prsnt_n, los, fault, xpll, gpll, txr, rxr, blk};
    {sp, sl, sf, sx, sg, str, srr, sb} = m_s;
    m_ft   = (m_count == MAXR) ? ST_HALT : ST_PULSE;
    m_next = m_state;
    if (!en)                                                m_next = ST_IDLE;
    else if (sp && m_state != ST_IDLE && m_state != ST_ABSENT) m_next = ST_ABSENT;
    else if (sf && m_state >= ST_WAIT_SIGNAL && m_state <= ST_LINK_UP) m_next = m_ft;
    else begin
      case (m_state)
        ST_IDLE: m_next = ST_ABSENT;
        ST_ABSENT: begin
          m_run = sp ? 0 : m_run + 1;
          if (m_run == DEB) m_next = ST_TX_INIT;
        end
        ST_TX_INIT: if (m_time + 1 == TXI) m_next = sf ? m_ft : ST_WAIT_SIGNAL;
        ST_WAIT_SIGNAL: begin
          m_run = sl ? 0 : m_run + 1;
          if (m_run == DEB) m_next = ST_PHY_RESET;
        end
        ST_PHY_RESET: if (m_time + 1 >= PHYC && sx && sg) m_next = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          if (str && srr && sb)     m_next = ST_LINK_UP;
          else if (m_time + 1 == TMO) m_next = ST_PHY_RESET;
          else if (sl)              m_next = ST_WAIT_SIGNAL;
        end
        ST_LINK_UP: begin
          if (sl) m_next = ST_WAIT_SIGNAL;
          else if (!sb || !srr || !sx || !sg) m_next = ST_PHY_RESET;
        end
        ST_PULSE: if (m_time + 1 == PUL) m_next = ST_TX_INIT;
        default: m_next = m_state;
      endcase
    end
    if (rst) begin
      m_state = ST_IDLE; m_time = 0; m_run = 0; m_count = 0;
    end else if (m_next != m_state) begin
      if (m_next == ST_PULSE && m_count < MAXR) m_count++;
      if (m_next == ST_IDLE || m_next == ST_ABSENT || m_next == ST_LINK_UP) m_count = 0;
      m_state = m_next; m_time = 0; m_run = 0;
    end else begin
      m_time++;
    end
    started = 1;
  end

  // Per-cycle comparison plus run-length monitors used by the directed scenarios.
  int   seq[$];
  logic [3:0] prev_st = '0;
  int   txd_run = 0, pulses5 = 0;
  int   phy_high = 0, phy_low = 0, low20 = 0, short_phy = 0;

  always @(negedge clk) begin
    if (started) begin
      check("state",       st,   m_state);
      check("tx_disable",  txd,  exp_txd[m_state]);
      check("phy_reset",   phy,  exp_phy[m_state]);
      check("link_up",     link, m_state == ST_LINK_UP);
      check("fault_halt",  halt, m_state == ST_HALT);
      check("fault_count", cnt,  m_count);
      if (st != prev_st) seq.push_back(int'(st));
      prev_st = st;
      if (txd) txd_run++;
      else begin
        if (txd_run == PUL) pulses5++;
        txd_run = 0;
      end
      if (phy) begin
        if (phy_low == TMO) low20++;
        phy_low = 0;
        phy_high++;
      end else begin
        if (phy_high > 0 && phy_high < PHYC) short_phy++;
        phy_high = 0;
        phy_low++;
      end
    end
  end

  initial begin
    rst = 1; en = 0; prsnt_n = 0; los = 0; fault = 0;
    xpll = 1; gpll = 1; txr = 0; rxr = 0; blk = 0;
    cycles(4);
    check("reset_state", st, 0);
    check("reset_txd",   txd, 1);
    check("reset_phy",   phy, 1);
    check("reset_count", cnt, 0);
    rst = 0;
    cycles(1);
    check("idle_while_disabled", st, 0);

    // Nominal bring-up
    seq.delete();
    en = 1;
    for (int i = 0; i < 100 && phy; i++) cycles(1);
    check("phy_reset_released", phy, 0);
    cycles(5);
    txr = 1; rxr = 1; blk = 1;
    for (int i = 0; i < 60 && !link; i++) cycles(1);
    check("nominal_link_up", link, 1);
    check("nominal_state", st, 6);
    check("nominal_count", cnt, 0);
    check("nominal_seq_len", seq.size(), 6);
    for (int i = 0; i < 6 && i < seq.size(); i++) check("nominal_seq", seq[i], i + 1);

    // Transient fault in LINK_UP
    fault = 1;
    cycles(2);
    fault = 0;
    cycles(2);
    check("transient_pulse_state", st, 7);
    check("transient_count", cnt, 1);
    for (int i = 0; i < 100 && !link; i++) cycles(1);
    check("transient_relink", link, 1);
    check("transient_count_cleared", cnt, 0);

    // Lock timeout: block_lock never returns
    low20 = 0; short_phy = 0;
    blk = 0;
    cycles(110);
    check("lock_timeout_windows", low20 >= 3, 1);
    check("lock_timeout_short_reset", short_phy, 0);

    // Removal together with tx_fault while in WAIT_LOCK
    for (int i = 0; i < 40 && st != 5; i++) cycles(1);
    check("reached_wait_lock", st, 5);
    prsnt_n = 1; fault = 1;
    cycles(3);
    check("removal_state", st, 1);
    check("removal_txd", txd, 1);
    check("removal_phy", phy, 1);
    check("removal_link", link, 0);

    // Presence glitch
    fault = 0; en = 0;
    cycles(2);
    en = 1;
    cycles(6);
    check("glitch_absent_before", st, 1);
    prsnt_n = 0; cycles(3);
    prsnt_n = 1; cycles(1);
    prsnt_n = 0; cycles(3);
    check("glitch_still_absent", st, 1);
    cycles(4);
    check("glitch_debounced", st, 2);

    // Permanent TX_FAULT
    en = 0; fault = 1;
    cycles(3);
    pulses5 = 0;
    en = 1;
    for (int i = 0; i < 300 && !halt; i++) cycles(1);
    check("halt_flag", halt, 1);
    check("halt_state", st, 8);
    check("halt_count", cnt, 3);
    check("halt_pulses", pulses5, 3);
    en = 0;
    cycles(2);
    check("halt_cleared_state", st, 0);
    check("halt_cleared_count", cnt, 0);
    fault = 0;

    // Randomized traffic, checked every cycle by the model
    for (int it = 0; it < 400; it++) begin
      rst     = ($urandom_range(0, 99) == 0);
      en      = ($urandom_range(0, 49) != 0);
      prsnt_n = ($urandom_range(0, 19) == 0);
      los     = ($urandom_range(0, 5) == 0);
      fault   = ($urandom_range(0, 24) == 0);
      xpll    = ($urandom_range(0, 15) != 0);
      gpll    = ($urandom_range(0, 15) != 0);
      txr     = ($urandom_range(0, 3) != 0);
      rxr     = ($urandom_range(0, 3) != 0);
      blk     = ($urandom_range(0, 3) != 0);
      if (it % 40 == 0) begin
        rst = 0; en = 1; prsnt_n = 0; los = 0; fault = 0;
        xpll = 1; gpll = 1; txr = 1; rxr = 1; blk = 1;
        cycles(60);
      end else begin
        cycles($urandom_range(1, 12));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
